// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, result
// select, ALU operation codes, decoded control bundle and small helpers.
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_RTYPE  = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_LUI    = 7'b0110111
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        result_src_t result_src;
        alu_ctrl_t   alu_ctrl;
        imm_src_t    imm_src;
        logic        illegal;
    } ctrl_t;

    typedef struct packed {
        logic      legal;
        alu_ctrl_t op;
    } alu_dec_t;

    // ALU operation for R-type/I-ALU from funct3; funct7[5] only matters
    // for R-type, where it is legal solely as the add->sub selector.
    function automatic alu_dec_t alu_decode(input logic [2:0] funct3,
                                            input logic       funct7_5,
                                            input logic       is_rtype);
        alu_dec_t d;
        d.legal = 1'b1;
        d.op    = ALU_ADD;
        case (funct3)
            3'b000:  d.op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  d.op = ALU_SLL;
            3'b010:  d.op = ALU_SLT;
            3'b100:  d.op = ALU_XOR;
            3'b101:  d.op = ALU_SRL;
            3'b110:  d.op = ALU_OR;
            3'b111:  d.op = ALU_AND;
            default: d.legal = 1'b0;
        endcase
        if (is_rtype && funct7_5 && (funct3 != 3'b000)) begin
            d.legal = 1'b0;
        end
        return d;
    endfunction

    // Sign-extended immediate for the selected instruction format.
    function automatic logic [31:0] imm_extend(input logic [31:0] instr,
                                               input imm_src_t    src);
        logic [31:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32-entry register file: two asynchronous read ports, one synchronous
// write port, x0 hard-wired to zero, synchronous clear on rst.
// Optional DECODE_WB_BYPASS_EN: a read of the register being written this
// cycle returns the write data (write-through).
module register_file
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] addr1,
    input  logic [REG_ADDR_W-1:0] addr2,
    output logic [XLEN-1:0]       rd1,
    output logic [XLEN-1:0]       rd2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata
);

    localparam int unsigned DEPTH = 2 ** REG_ADDR_W;

    logic [XLEN-1:0] regs [DEPTH];
    logic            wr_en;

    assign wr_en = we && (waddr != '0);

    // Synchronous clear on reset, otherwise write any register except x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Asynchronous read ports; x0 always reads zero.
    always_comb begin
        rd1 = (addr1 == '0) ? '0 : regs[addr1];
        rd2 = (addr2 == '0) ? '0 : regs[addr2];
`ifdef DECODE_WB_BYPASS_EN
        if (wr_en && (addr1 == waddr)) begin
            rd1 = wdata;
        end
        if (wr_en && (addr2 == waddr)) begin
            rd2 = wdata;
        end
`endif
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extension
// and the ID/EX pipeline register (priority rst > FlushE > StallE > load).
// Build option DECODE_WB_BYPASS_EN enables write-through in register_file.
module decode_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           InstrD,
    input  logic [XLEN-1:0]       PCD,
    input  logic [XLEN-1:0]       PCPlus4D,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RDW,
    input  logic [XLEN-1:0]       ResultW,
    input  logic                  FlushE,
    input  logic                  StallE,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic                  ALUSrcE,
    output logic [1:0]            ResultSrcE,
    output logic [2:0]            ALUControlE,
    output logic [XLEN-1:0]       RD1E,
    output logic [XLEN-1:0]       RD2E,
    output logic [XLEN-1:0]       ImmExtE,
    output logic [XLEN-1:0]       PCE,
    output logic [XLEN-1:0]       PCPlus4E,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic                  ValidE,
    output logic                  IllegalE
);

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic                  alu_src;
        result_src_t           result_src;
        alu_ctrl_t             alu_ctrl;
        logic                  illegal;
        logic                  valid;
        logic [XLEN-1:0]       rd1;
        logic [XLEN-1:0]       rd2;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       pc4;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } idex_t;

    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic [REG_ADDR_W-1:0] rd_d;
    logic [2:0]            funct3;
    logic                  funct7_5;
    logic [XLEN-1:0]       rf_rd1;
    logic [XLEN-1:0]       rf_rd2;
    ctrl_t                 dec;
    alu_dec_t              ad;
    idex_t                 idex_d;
    idex_t                 idex_q;

    assign rs1_d    = InstrD[19:15];
    assign rs2_d    = InstrD[24:20];
    assign rd_d     = InstrD[11:7];
    assign funct3   = InstrD[14:12];
    assign funct7_5 = InstrD[30];

    register_file #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_register_file (
        .clk   (clk),
        .rst   (rst),
        .addr1 (rs1_d),
        .addr2 (rs2_d),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (RegWriteW),
        .waddr (RDW),
        .wdata (ResultW)
    );

    // Main decoder: opcode plus funct3/funct7[5] to control bundle.
    always_comb begin
        dec = '0;
        ad  = '{legal: 1'b1, op: ALU_ADD};
        case (opcode_t'(InstrD[6:0]))
            OP_RTYPE: begin
                ad            = alu_decode(funct3, funct7_5, 1'b1);
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = ad.op;
                dec.illegal   = !ad.legal;
            end
            OP_IALU: begin
                ad            = alu_decode(funct3, funct7_5, 1'b0);
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ad.op;
                dec.imm_src   = IMM_I;
                dec.illegal   = !ad.legal;
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
                dec.imm_src    = IMM_I;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_S;
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                dec.imm_src  = IMM_B;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = RES_PC4;
                dec.imm_src    = IMM_J;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_U;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Next ID/EX contents when the stage loads a new instruction.
    always_comb begin
        idex_d            = '0;
        idex_d.reg_write  = dec.reg_write;
        idex_d.mem_write  = dec.mem_write;
        idex_d.jump       = dec.jump;
        idex_d.branch     = dec.branch;
        idex_d.alu_src    = dec.alu_src;
        idex_d.result_src = dec.result_src;
        idex_d.alu_ctrl   = dec.alu_ctrl;
        idex_d.illegal    = dec.illegal;
        idex_d.valid      = 1'b1;
        idex_d.rd1        = rf_rd1;
        idex_d.rd2        = rf_rd2;
        idex_d.imm        = imm_extend(InstrD, dec.imm_src);
        idex_d.pc         = PCD;
        idex_d.pc4        = PCPlus4D;
        idex_d.rs1        = rs1_d;
        idex_d.rs2        = rs2_d;
        idex_d.rd         = rd_d;
    end

    // ID/EX pipeline register: reset and flush both produce a bubble.
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            idex_q <= '0;
        end else if (!StallE) begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign JumpE       = idex_q.jump;
    assign BranchE     = idex_q.branch;
    assign ALUSrcE     = idex_q.alu_src;
    assign ResultSrcE  = idex_q.result_src;
    assign ALUControlE = idex_q.alu_ctrl;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc4;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;
    assign ValidE      = idex_q.valid;
    assign IllegalE    = idex_q.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: an instruction-level model of the
// stage is compared against the DUT every cycle, plus literal expectations
// for the hand-assembled instructions.
module tb_decode_cycle;

    logic        clk_tb = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE, StallE;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ValidE, IllegalE;

    int n_checks = 0;
    int n_fail   = 0;

    decode_cycle #(
        .XLEN       (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk         (clk_tb),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .FlushE      (FlushE),
        .StallE      (StallE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .ValidE      (ValidE),
        .IllegalE    (IllegalE)
    );

    always #5 clk_tb = ~clk_tb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    typedef struct packed {
        logic        rw, mw, j, b, as;
        logic [1:0]  rs;
        logic [2:0]  alu;
        logic        valid, ill;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } exp_t;

    exp_t        m;
    exp_t        m_next;
    logic        m_imm_care;
    logic        m_next_care;
    logic [31:0] mrf [32];

    // ALU code by funct3: add, sll, slt, (none), xor, srl, or, and
    int alu_of_f3 [8] = '{0, 6, 5, -1, 4, 7, 3, 2};

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (RegWriteW && RDW == a) return ResultW;
`endif
        return mrf[a];
    endfunction

    function automatic exp_t model_decode(input logic [31:0] instr, input logic [31:0] pc,
                                          input logic [31:0] pc4, output logic care);
        exp_t e;
        int   f3, a;
        e     = '0;
        care  = 1'b1;
        f3    = int'(instr[14:12]);
        a     = alu_of_f3[f3];
        e.valid = 1'b1;
        e.rs1 = instr[19:15];
        e.rs2 = instr[24:20];
        e.rd  = instr[11:7];
        e.rd1 = rf_read(instr[19:15]);
        e.rd2 = rf_read(instr[24:20]);
        e.pc  = pc;
        e.pc4 = pc4;
        case (instr[6:0])
            7'h33: begin
                care = 1'b0;
                if (a < 0 || (instr[30] && f3 != 0)) e.ill = 1'b1;
                else begin
                    e.rw  = 1'b1;
                    e.alu = instr[30] ? 3'd1 : 3'(a);
                end
            end
            7'h13: begin
                if (a < 0) e.ill = 1'b1;
                else begin
                    e.rw = 1'b1; e.as = 1'b1; e.alu = 3'(a);
                    e.imm = sx(int'(instr[31:20]), 12);
                end
            end
            7'h03: begin
                e.rw = 1'b1; e.as = 1'b1; e.rs = 2'd1;
                e.imm = sx(int'(instr[31:20]), 12);
            end
            7'h23: begin
                e.mw = 1'b1; e.as = 1'b1;
                e.imm = sx(int'(instr[31:25]) * 32 + int'(instr[11:7]), 12);
            end
            7'h63: begin
                e.b = 1'b1; e.alu = 3'd1;
                e.imm = sx(int'(instr[31]) * 4096 + int'(instr[7]) * 2048
                           + int'(instr[30:25]) * 32 + int'(instr[11:8]) * 2, 13);
            end
            7'h6F: begin
                e.rw = 1'b1; e.j = 1'b1; e.rs = 2'd2;
                e.imm = sx(int'(instr[31]) * (1 << 20) + int'(instr[19:12]) * 4096
                           + int'(instr[20]) * 2048 + int'(instr[30:21]) * 2, 21);
            end
            7'h37: begin
                e.rw = 1'b1; e.as = 1'b1;
                e.imm = instr & 32'hFFFF_F000;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) care = 1'b0;
        return e;
    endfunction

    // Model advances on each rising edge using the inputs presented there.
    always @(posedge clk_tb) begin
        if (rst) begin
            m          = '0;
            m_imm_care = 1'b1;
            for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        end else begin
            m_next = model_decode(InstrD, PCD, PCPlus4D, m_next_care);
            if (FlushE) begin
                m          = '0;
                m_imm_care = 1'b1;
            end else if (!StallE) begin
                m          = m_next;
                m_imm_care = m_next_care;
            end
            if (RegWriteW && RDW != 5'd0) mrf[RDW] = ResultW;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk_tb) begin
        #1;
        chk("ctrl", {20'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
                     ALUControlE, ValidE, IllegalE},
                    {20'd0, m.rw, m.mw, m.j, m.b, m.as, m.rs, m.alu, m.valid, m.ill});
        chk("RD1E", RD1E, m.rd1);
        chk("RD2E", RD2E, m.rd2);
        if (m_imm_care) chk("ImmExtE", ImmExtE, m.imm);
        chk("PCE", PCE, m.pc);
        chk("PCPlus4E", PCPlus4E, m.pc4);
        chk("regidx", {17'd0, Rs1E, Rs2E, RdE}, {17'd0, m.rs1, m.rs2, m.rd});
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] pc = 32'h0000_1000;

    task automatic step(input logic [31:0] instr);
        InstrD   = instr;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
        pc       = pc + 32'd4;
        @(posedge clk_tb);
        #2;
    endtask

    initial begin
        rst       = 1'b1;
        InstrD    = 32'hFFFF_FFFF;
        PCD       = 32'hA5A5_A5A5;
        PCPlus4D  = 32'h5A5A_5A5A;
        RegWriteW = 1'b1;
        RDW       = 5'd5;
        ResultW   = 32'hBAD0_BAD0;
        FlushE    = 1'b0;
        StallE    = 1'b0;
        repeat (2) begin
            @(posedge clk_tb);
            #2;
        end
        chk("rst_valid", {31'd0, ValidE}, 32'd0);
        chk("rst_regwrite", {31'd0, RegWriteE}, 32'd0);
        chk("rst_imm", ImmExtE, 32'd0);
        chk("rst_pc", PCE, 32'd0);

        rst       = 1'b0;
        RegWriteW = 1'b0;
        step(32'h0002_8093);                 // addi x1,x5,0
        chk("x5_after_rst", RD1E, 32'd0);
        chk("x5_rs1", {27'd0, Rs1E}, 32'd5);

        step(32'h0050_0093);                 // addi x1,x0,5
        chk("addi_regwrite", {31'd0, RegWriteE}, 32'd1);
        chk("addi_alusrc", {31'd0, ALUSrcE}, 32'd1);
        chk("addi_aluctl", {29'd0, ALUControlE}, 32'd0);
        chk("addi_imm", ImmExtE, 32'd5);
        chk("addi_rd", {27'd0, RdE}, 32'd1);
        chk("addi_rs1", {27'd0, Rs1E}, 32'd0);
        chk("addi_rd1", RD1E, 32'd0);
        chk("addi_valid", {31'd0, ValidE}, 32'd1);

        RegWriteW = 1'b1; RDW = 5'd2; ResultW = 32'hDEAD_BEEF;
        step(32'h0000_0013);                 // nop while x2 is written
        RegWriteW = 1'b0;
        step(32'h0021_01B3);                 // add x3,x2,x2
        chk("wr_rd1", RD1E, 32'hDEAD_BEEF);
        chk("wr_rd2", RD2E, 32'hDEAD_BEEF);
        chk("wr_rd", {27'd0, RdE}, 32'd3);

        RegWriteW = 1'b1; RDW = 5'd4; ResultW = 32'hCAFE_F00D;
        step(32'h0042_01B3);                 // add x3,x4,x4 with same-cycle write
        RegWriteW = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
        chk("bypass_rd1", RD1E, 32'hCAFE_F00D);
        chk("bypass_rd2", RD2E, 32'hCAFE_F00D);
`else
        chk("nobypass_rd1", RD1E, 32'd0);
        chk("nobypass_rd2", RD2E, 32'd0);
`endif

        step(32'hFE20_8CE3);                 // beq x1,x2,-8
        chk("beq_branch", {31'd0, BranchE}, 32'd1);
        chk("beq_aluctl", {29'd0, ALUControlE}, 32'd1);
        chk("beq_imm", ImmExtE, 32'hFFFF_FFF8);
        chk("beq_regwrite", {31'd0, RegWriteE}, 32'd0);
        chk("beq_rs1", {27'd0, Rs1E}, 32'd1);
        chk("beq_rs2", {27'd0, Rs2E}, 32'd2);

        RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'h0000_1234;
        step(32'h0000_0013);
        RegWriteW = 1'b0;
        step(32'h0000_01B3);                 // add x3,x0,x0
        chk("x0_rd1", RD1E, 32'd0);
        chk("x0_rd2", RD2E, 32'd0);

        step(32'h0100_00EF);                 // jal x1,+16
        chk("jal_imm", ImmExtE, 32'd16);
        chk("jal_jump", {31'd0, JumpE}, 32'd1);
        chk("jal_ressrc", {30'd0, ResultSrcE}, 32'd2);
        step(32'h1234_52B7);                 // lui x5,0x12345
        chk("lui_imm", ImmExtE, 32'h1234_5000);
        step(32'hFE20_AE23);                 // sw x2,-4(x1)
        chk("sw_imm", ImmExtE, 32'hFFFF_FFFC);
        chk("sw_memwrite", {31'd0, MemWriteE}, 32'd1);
        step(32'h0080_A183);                 // lw x3,8(x1)
        chk("lw_ressrc", {30'd0, ResultSrcE}, 32'd1);
        step(32'h4020_81B3);                 // sub x3,x1,x2
        chk("sub_aluctl", {29'd0, ALUControlE}, 32'd1);
        step(32'h4020_D1B3);                 // sra: not supported
        chk("sra_illegal", {31'd0, IllegalE}, 32'd1);
        step(32'h4010_D193);                 // srai decodes as srl
        chk("srai_aluctl", {29'd0, ALUControlE}, 32'd7);
        chk("srai_illegal", {31'd0, IllegalE}, 32'd0);

        step(32'h0050_0093);                 // addi x1,x0,5 then hold
        StallE = 1'b1;
        RegWriteW = 1'b1; RDW = 5'd7; ResultW = 32'h0000_0077;
        for (int i = 0; i < 3; i++) begin
            step(32'hFE20_8CE3);
            RegWriteW = 1'b0;
            chk("stall_regwrite", {31'd0, RegWriteE}, 32'd1);
            chk("stall_imm", ImmExtE, 32'd5);
            chk("stall_branch", {31'd0, BranchE}, 32'd0);
        end
        FlushE = 1'b1;
        step(32'h0050_0093);                 // flush beats stall
        chk("flush_valid", {31'd0, ValidE}, 32'd0);
        chk("flush_regwrite", {31'd0, RegWriteE}, 32'd0);
        chk("flush_imm", ImmExtE, 32'd0);
        FlushE = 1'b0;
        StallE = 1'b0;
        step(32'h0003_81B3);                 // add x3,x7,x0: write during stall landed
        chk("stall_write_x7", RD1E, 32'h0000_0077);

        step(32'h0000_007F);                 // unsupported opcode
        chk("ill_illegal", {31'd0, IllegalE}, 32'd1);
        chk("ill_valid", {31'd0, ValidE}, 32'd1);
        chk("ill_ctrl", {24'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
                         ALUControlE == 3'd0}, 32'd1);

        rst = 1'b1;                          // reset mid-stream
        step(32'h0021_01B3);
        chk("rst2_valid", {31'd0, ValidE}, 32'd0);
        rst = 1'b0;
        step(32'h0021_01B3);                 // x2 cleared by reset
        chk("rst2_x2", RD1E, 32'd0);
        step(32'h0000_0013);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second pipeline stage of the 32-bit RISC-V core, directly downstream of `fetch_cycle`. It consumes `InstrD`/`PCD`/`PCPlus4D` and decodes the RV32I instruction into control signals. It reads two operands from the 32×32 register file, which is written by the write-back stage, and sign-extends the immediate. All of this is registered into the ID/EX pipeline register that feeds the execute stage.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `REG_ADDR_W`, 5, register index width.

Ports:
- `clk`  in  1  core clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `InstrD`  in  32  instruction from fetch.
- `PCD`  in  32  PC of `InstrD`.
- `PCPlus4D`  in  32  PC+4 of `InstrD`.
- `RegWriteW`  in  1  write-back write enable.
- `RDW`  in  5  write-back destination register.
- `ResultW`  in  32  write-back data.
- `FlushE`  in  1  load a bubble into ID/EX.
- `StallE`  in  1  hold ID/EX contents.
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE`  out  1 each  registered control bits.
- `ResultSrcE`  out  2  result select: 00 ALU, 01 memory, 10 PC+4.
- `ALUControlE`  out  3  ALU operation code.
- `RD1E`, `RD2E`, `ImmExtE`, `PCE`, `PCPlus4E`  out  32 each  registered datapath values.
- `Rs1E`, `Rs2E`, `RdE`  out  5 each  registered register indices, used by the hazard unit.
- `ValidE`  out  1  ID/EX holds a real instruction.
- `IllegalE`  out  1  the instruction in ID/EX had an unsupported opcode or funct.

## Operation
- **Control decode.** Decoding is combinational from `InstrD[6:0]`, `funct3` and `funct7[5]`.
- **Supported opcodes.** R-type (0110011), I-ALU (0010011), load (0000011), store (0100011), branch (1100011), jal (1101111), lui (0110111).
- **ALU control codes.** 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- **Add vs. sub.** For R-type, `funct7[5]`=1 selects sub. For I-type, `funct7[5]` is ignored, so there is no subi.
- **Branches.** Branches use ALU sub.
- **Unsupported encodings.** An unsupported opcode or funct produces all control bits 0 and `IllegalE`=1 on load. `ValidE` is still 1.
- **Immediate.** The immediate format is I, S, B, J or U, chosen by opcode. The result is sign-extended from bit 31; U-type is `{Instr[31:12], 12'b0}`. Formats I/S/B/J are 12/12/13/21-bit signed, with bit 0 = 0 for B and J.
- **Register file.** Two asynchronous read ports, one synchronous write port. A write occurs at the rising edge when `RegWriteW`=1 and `RDW`≠0. x0 always reads 0, and writes to x0 are discarded.
- **ID/EX update priority.** Evaluated each rising edge in this order: `rst` > `FlushE` > `StallE` > load.
  - rst: every output and every regfile entry is cleared to 0.
  - FlushE: bubble; every output = 0, so `ValidE`=0.
  - StallE: all outputs hold their values.
  - otherwise: load the decoded values and set `ValidE`=1.
- **Flush and stall together.** When `FlushE` and `StallE` are both high, the flush wins.
- **Regfile during flush/stall.** Register-file writes proceed regardless of `FlushE`/`StallE`. Only `rst` blocks them.
- **Reset mid-operation.** The pipeline register and the register file clear on the same edge. The first load after `rst` falls carries whatever is on `InstrD` at that edge.

## Timing
- **Latency.** 1 cycle from `InstrD` to the `*E` outputs.
- **Reset values.** All outputs read 0 from the first edge with `rst`=1.
- **Same-cycle read/write.** A write-back write to register N and a decode read of register N in the same cycle: see Configuration.
- **Combinational paths.** None from inputs to outputs; every output comes from a flop.

## Configuration
- **`DECODE_WB_BYPASS_EN` defined.** A read port whose address equals `RDW` while `RegWriteW`=1 and `RDW`≠0 returns `ResultW` in the same cycle. This is write-through, so ID/EX captures the new value.
- **`DECODE_WB_BYPASS_EN` undefined.** A read returns the stored (old) value. The hazard unit must then stall or forward.

## Structure
- **Shared package `riscv_pkg`.** Holds:
  - opcode constants;
  - `ImmSrc` encodings (I=000, S=001, B=010, J=011, U=100);
  - `ResultSrc` encodings;
  - ALU-control constants.
- **Sub-module `register_file`.** Owns the 32×32 array, x0 handling and the bypass macro.
- **Remaining logic.** The decoder, immediate extender and ID/EX register stay in `decode_cycle`.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with garbage on `InstrD` → every output is 0. Afterwards, reading x5 gives 0.
- **addi.** `InstrD`=0x00500093 (addi x1,x0,5) → next cycle:
  - RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5;
  - RdE=1, Rs1E=0, RD1E=0, ValidE=1.
- **Write then read.** Write 0xDEADBEEF to x2 via `RegWriteW`/`RDW`=2. On the following cycle, `InstrD`=0x002101B3 (add x3,x2,x2) → RD1E=RD2E=0xDEADBEEF, RdE=3. With the bypass enabled, repeat with the write and the decode in the same cycle → the same values.
- **Branch.** `InstrD`=0xFE208CE3 (beq x1,x2,-8) → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8, RegWriteE=0, Rs1E=1, Rs2E=2.
- **x0 write.** RDW=0, ResultW=0x1234, RegWriteW=1, then decode add x3,x0,x0 → RD1E=RD2E=0.
- **Flush, stall and illegal.**
  - Load addi, then set StallE=1 for 3 cycles → outputs are unchanged.
  - Set StallE=1 and FlushE=1 together → all outputs 0, ValidE=0.
  - `InstrD`=0x0000007F → IllegalE=1, all control bits 0.
